// File: rtl/test_cpuif_if.sv
// ============================================================================
// test_cpuif_if : asynchronous 16-bit CPU bus bundle for test_cpuif
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface test_cpuif_if;
   logic        cpu_cs_n;
   logic        cpu_wr_n;
   logic        cpu_rd_n;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_rdata_oe_n;

   modport master (
      output cpu_cs_n, cpu_wr_n, cpu_rd_n, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_rdata_oe_n
   );

   modport slave (
      input  cpu_cs_n, cpu_wr_n, cpu_rd_n, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_rdata_oe_n
   );
endinterface

`default_nettype wire

// File: rtl/test_cpuif.sv
// ============================================================================
// test_cpuif : CPU register block for test_core (patterns, control, status)
// Optional done interrupt enabled by macro CPUIF_IRQ_EN.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module test_cpuif #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] ID_VALUE    = 16'h5450
) (
   input  logic        clk_50m,
   input  logic        rst_core_n,
   test_cpuif_if.slave cpu,
   output logic        cpuif_core_test_start,
   output logic        cpuif_core_test_end,
   output logic [23:0] cpuif_core_test_00,
   output logic [23:0] cpuif_core_test_01,
   output logic [23:0] cpuif_core_test_02,
   output logic [23:0] cpuif_core_test_03,
   output logic [23:0] cpuif_core_test_04,
   output logic [23:0] cpuif_core_test_05,
   output logic [23:0] cpuif_core_test_06,
   output logic [23:0] cpuif_core_test_07,
   output logic [23:0] cpuif_core_test_08,
   output logic [23:0] cpuif_core_test_09,
   output logic [23:0] cpuif_core_test_10,
   output logic [23:0] cpuif_core_test_11,
   output logic [23:0] cpuif_core_test_12,
   output logic [23:0] cpuif_core_test_13,
   output logic [23:0] cpuif_core_test_14,
   output logic [23:0] cpuif_core_test_15,
   input  logic        core_cpuif_d_err,
   input  logic        core_cpuif_a_err,
   input  logic        core_cpuif_s_end,
   input  logic        core_cpuif_s_busy
`ifdef CPUIF_IRQ_EN
   ,
   output logic        cpuif_irq
`endif
);

   localparam logic [7:0] c_addr_ctrl   = 8'h00;
   localparam logic [7:0] c_addr_status = 8'h01;
   localparam logic [7:0] c_addr_irq    = 8'h02;
   localparam logic [7:0] c_addr_id     = 8'h03;

   logic [SYNC_STAGES-1:0] r_wr_sync;
   logic [SYNC_STAGES-1:0] r_rd_sync;
   logic                   r_wr_d;
   logic                   r_start_req;
   logic                   r_end_req;
   logic [23:0]            r_pat [16];

   logic                   w_wr_s;
   logic                   w_rd_s;
   logic                   w_wr_rise;
   logic                   w_rd_lvl;
   logic                   w_pat_hit;
   logic [3:0]             w_pat_idx;
   logic                   w_irq_rd;
   logic [15:0]            w_rd_mux;

   assign w_wr_s    = ~(cpu.cpu_cs_n | cpu.cpu_wr_n);
   assign w_rd_s    = ~(cpu.cpu_cs_n | cpu.cpu_rd_n);
   assign w_wr_rise = r_wr_sync[SYNC_STAGES-1] & ~r_wr_d;
   assign w_rd_lvl  = r_rd_sync[SYNC_STAGES-1];

   // Patterns occupy 0x10..0x2F; index wraps so 0x10 -> 0 and 0x2E -> 15
   assign w_pat_hit = (cpu.cpu_addr >= 8'h10) && (cpu.cpu_addr <= 8'h2F);
   assign w_pat_idx = cpu.cpu_addr[4:1] - 4'h8;

   always_comb begin
      w_rd_mux = 16'h0000;
      if (w_pat_hit) begin
         if (cpu.cpu_addr[0])
            w_rd_mux = {8'h00, r_pat[w_pat_idx][23:16]};
         else
            w_rd_mux = r_pat[w_pat_idx][15:0];
      end else begin
         case (cpu.cpu_addr)
            c_addr_status: w_rd_mux = {12'h000, core_cpuif_a_err, core_cpuif_d_err,
                                       core_cpuif_s_end, core_cpuif_s_busy};
            c_addr_irq:    w_rd_mux = {15'h0000, w_irq_rd};
            c_addr_id:     w_rd_mux = ID_VALUE;
            default:       w_rd_mux = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk_50m or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_wr_sync             <= '0;
         r_rd_sync             <= '0;
         r_wr_d                <= 1'b0;
         r_start_req           <= 1'b0;
         r_end_req             <= 1'b0;
         cpuif_core_test_start <= 1'b0;
         cpuif_core_test_end   <= 1'b0;
         cpu.cpu_rdata         <= 16'h0000;
         cpu.cpu_rdata_oe_n    <= 1'b1;
         for (int i = 0; i < 16; i++) r_pat[i] <= 24'h000000;
      end else begin
         r_wr_sync             <= {r_wr_sync[SYNC_STAGES-2:0], w_wr_s};
         r_rd_sync             <= {r_rd_sync[SYNC_STAGES-2:0], w_rd_s};
         r_wr_d                <= r_wr_sync[SYNC_STAGES-1];
         r_start_req           <= 1'b0;
         r_end_req             <= 1'b0;
         cpuif_core_test_start <= r_start_req;
         cpuif_core_test_end   <= r_end_req;

         if (w_wr_rise) begin
            if (cpu.cpu_addr == c_addr_ctrl) begin
               // Start has priority: a combined request only starts
               r_start_req <= cpu.cpu_wdata[0];
               r_end_req   <= cpu.cpu_wdata[1] & ~cpu.cpu_wdata[0];
            end else if (w_pat_hit && !core_cpuif_s_busy) begin
               if (cpu.cpu_addr[0])
                  r_pat[w_pat_idx][23:16] <= cpu.cpu_wdata[7:0];
               else
                  r_pat[w_pat_idx][15:0]  <= cpu.cpu_wdata;
            end
         end

         if (w_rd_lvl) cpu.cpu_rdata <= w_rd_mux;
         cpu.cpu_rdata_oe_n <= ~w_rd_lvl;
      end
   end

`ifdef CPUIF_IRQ_EN
   logic r_send_d;
   logic r_busy_d;
   logic r_irq_pend;
   logic w_irq_set;
   logic w_irq_clr;

   // Done = rising s_end; abort = busy falling without s_end
   assign w_irq_set = (core_cpuif_s_end & ~r_send_d) |
                      (~core_cpuif_s_busy & r_busy_d & ~core_cpuif_s_end);
   assign w_irq_clr = w_wr_rise && (cpu.cpu_addr == c_addr_irq) && cpu.cpu_wdata[0];
   assign w_irq_rd  = r_irq_pend;

   always_ff @(posedge clk_50m or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_send_d   <= 1'b0;
         r_busy_d   <= 1'b0;
         r_irq_pend <= 1'b0;
         cpuif_irq  <= 1'b0;
      end else begin
         r_send_d  <= core_cpuif_s_end;
         r_busy_d  <= core_cpuif_s_busy;
         if (w_irq_set)
            r_irq_pend <= 1'b1;
         else if (w_irq_clr)
            r_irq_pend <= 1'b0;
         cpuif_irq <= r_irq_pend;
      end
   end
`else
   assign w_irq_rd = 1'b0;
`endif

   assign cpuif_core_test_00 = r_pat[0];
   assign cpuif_core_test_01 = r_pat[1];
   assign cpuif_core_test_02 = r_pat[2];
   assign cpuif_core_test_03 = r_pat[3];
   assign cpuif_core_test_04 = r_pat[4];
   assign cpuif_core_test_05 = r_pat[5];
   assign cpuif_core_test_06 = r_pat[6];
   assign cpuif_core_test_07 = r_pat[7];
   assign cpuif_core_test_08 = r_pat[8];
   assign cpuif_core_test_09 = r_pat[9];
   assign cpuif_core_test_10 = r_pat[10];
   assign cpuif_core_test_11 = r_pat[11];
   assign cpuif_core_test_12 = r_pat[12];
   assign cpuif_core_test_13 = r_pat[13];
   assign cpuif_core_test_14 = r_pat[14];
   assign cpuif_core_test_15 = r_pat[15];

endmodule

`default_nettype wire

// File: tb/tb_test_cpuif.sv
// ============================================================================
// tb_test_cpuif : directed self-checking bench for test_cpuif
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_test_cpuif;
   logic        clk_50m = 1'b0;
   logic        rst_core_n;
   logic        start_p, end_p;
   logic [23:0] pat [16];
   logic        d_err, a_err, s_end, s_busy;
`ifdef CPUIF_IRQ_EN
   logic        irq;
`endif
   int          n_checks = 0;
   int          n_pass   = 0;

   test_cpuif_if cpu_bus ();

   always #10 clk_50m = ~clk_50m;

   test_cpuif #(.SYNC_STAGES(2), .ID_VALUE(16'h5450)) dut (
      .clk_50m               (clk_50m),
      .rst_core_n            (rst_core_n),
      .cpu                   (cpu_bus),
      .cpuif_core_test_start (start_p),
      .cpuif_core_test_end   (end_p),
      .cpuif_core_test_00    (pat[0]),
      .cpuif_core_test_01    (pat[1]),
      .cpuif_core_test_02    (pat[2]),
      .cpuif_core_test_03    (pat[3]),
      .cpuif_core_test_04    (pat[4]),
      .cpuif_core_test_05    (pat[5]),
      .cpuif_core_test_06    (pat[6]),
      .cpuif_core_test_07    (pat[7]),
      .cpuif_core_test_08    (pat[8]),
      .cpuif_core_test_09    (pat[9]),
      .cpuif_core_test_10    (pat[10]),
      .cpuif_core_test_11    (pat[11]),
      .cpuif_core_test_12    (pat[12]),
      .cpuif_core_test_13    (pat[13]),
      .cpuif_core_test_14    (pat[14]),
      .cpuif_core_test_15    (pat[15]),
      .core_cpuif_d_err      (d_err),
      .core_cpuif_a_err      (a_err),
      .core_cpuif_s_end      (s_end),
      .core_cpuif_s_busy     (s_busy)
`ifdef CPUIF_IRQ_EN
      ,
      .cpuif_irq             (irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [15:0] data);
      @(negedge clk_50m);
      cpu_bus.cpu_addr  = addr;
      cpu_bus.cpu_wdata = data;
      cpu_bus.cpu_cs_n  = 1'b0;
      cpu_bus.cpu_wr_n  = 1'b0;
      repeat (5) @(negedge clk_50m);
      cpu_bus.cpu_cs_n  = 1'b1;
      cpu_bus.cpu_wr_n  = 1'b1;
      repeat (4) @(negedge clk_50m);
   endtask

   // Read: data and oe_n must be valid 3 clocks after strobe, oe_n released after
   task automatic cpu_read(input logic [7:0] addr, input string tag, input logic [15:0] exp);
      logic [15:0] got;
      @(negedge clk_50m);
      cpu_bus.cpu_addr = addr;
      cpu_bus.cpu_cs_n = 1'b0;
      cpu_bus.cpu_rd_n = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      got = cpu_bus.cpu_rdata;
      check({tag, "_oe"}, {31'd0, cpu_bus.cpu_rdata_oe_n}, 32'd0);
      check(tag, {16'd0, got}, {16'd0, exp});
      @(negedge clk_50m);
      cpu_bus.cpu_cs_n = 1'b1;
      cpu_bus.cpu_rd_n = 1'b1;
      repeat (4) @(posedge clk_50m);
      #1;
      check({tag, "_oe_off"}, {31'd0, cpu_bus.cpu_rdata_oe_n}, 32'd1);
      check({tag, "_hold"}, {16'd0, cpu_bus.cpu_rdata}, {16'd0, exp});
   endtask

   // CTRL write with long strobe; records pulse counts and first cycle seen
   task automatic ctrl_write(input logic [15:0] data, output int ns, output int fs,
                             output int ne, output int fe);
      ns = 0; fs = 0; ne = 0; fe = 0;
      @(negedge clk_50m);
      cpu_bus.cpu_addr  = 8'h00;
      cpu_bus.cpu_wdata = data;
      cpu_bus.cpu_cs_n  = 1'b0;
      cpu_bus.cpu_wr_n  = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk_50m);
         #1;
         if (start_p) begin ns++; if (fs == 0) fs = k; end
         if (end_p)   begin ne++; if (fe == 0) fe = k; end
         if (k == 10) begin
            @(negedge clk_50m);
            cpu_bus.cpu_cs_n = 1'b1;
            cpu_bus.cpu_wr_n = 1'b1;
         end
      end
   endtask

   initial begin
      int ns, fs, ne, fe;
      cpu_bus.cpu_cs_n  = 1'b1;
      cpu_bus.cpu_wr_n  = 1'b1;
      cpu_bus.cpu_rd_n  = 1'b1;
      cpu_bus.cpu_addr  = 8'h00;
      cpu_bus.cpu_wdata = 16'h0000;
      d_err = 1'b0; a_err = 1'b0; s_end = 1'b0; s_busy = 1'b0;
      rst_core_n = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      check("rst_oe_n", {31'd0, cpu_bus.cpu_rdata_oe_n}, 32'd1);
      check("rst_rdata", {16'd0, cpu_bus.cpu_rdata}, 32'd0);
      check("rst_start", {31'd0, start_p}, 32'd0);
      check("rst_end", {31'd0, end_p}, 32'd0);
      @(negedge clk_50m);
      rst_core_n = 1'b1;
      for (int i = 0; i < 16; i++) check($sformatf("rst_pat%0d", i), {8'd0, pat[i]}, 32'd0);

      cpu_read(8'h03, "rd_id", 16'h5450);

      cpu_write(8'h10, 16'hBEEF);
      cpu_write(8'h11, 16'h12A5);
      check("pat00", {8'd0, pat[0]}, 32'h00A5BEEF);
      cpu_read(8'h11, "rd_pat00_hi", 16'h00A5);
      cpu_read(8'h10, "rd_pat00_lo", 16'hBEEF);
      check("pat01_untouched", {8'd0, pat[1]}, 32'd0);

      ctrl_write(16'h0001, ns, fs, ne, fe);
      check("start_count", ns, 1);
      check("start_cycle", fs, 4);
      check("start_no_end", ne, 0);

      s_busy = 1'b1;
      cpu_write(8'h2E, 16'h1234);
      check("pat15_locked", {8'd0, pat[15]}, 32'd0);
      s_busy = 1'b0;
      cpu_write(8'h2E, 16'h1234);
      check("pat15_written", {8'd0, pat[15]}, 32'h00001234);
      cpu_read(8'h2F, "rd_pat15_hi", 16'h0000);

      ctrl_write(16'h0003, ns, fs, ne, fe);
      check("both_start", ns, 1);
      check("both_end", ne, 0);
      ctrl_write(16'h0002, ns, fs, ne, fe);
      check("end_count", ne, 1);
      check("end_cycle", fe, 4);
      check("end_no_start", ns, 0);

      a_err = 1'b1; d_err = 1'b0; s_end = 1'b1; s_busy = 1'b0;
      cpu_read(8'h01, "rd_status_a", 16'h000A);
      a_err = 1'b0; d_err = 1'b1; s_end = 1'b0; s_busy = 1'b1;
      cpu_read(8'h01, "rd_status_b", 16'h0005);
      s_busy = 1'b0; d_err = 1'b0;
      cpu_read(8'h00, "rd_ctrl", 16'h0000);
      cpu_read(8'h30, "rd_unmapped", 16'h0000);

`ifdef CPUIF_IRQ_EN
      repeat (3) @(negedge clk_50m);
      cpu_write(8'h02, 16'h0001);
      repeat (2) @(posedge clk_50m);
      #1;
      check("irq_cleared0", {31'd0, irq}, 32'd0);
      @(negedge clk_50m);
      s_end = 1'b1;
      repeat (3) @(posedge clk_50m);
      #1;
      check("irq_done", {31'd0, irq}, 32'd1);
      cpu_read(8'h02, "rd_irq_set", 16'h0001);
      s_end = 1'b0;
      cpu_write(8'h02, 16'h0001);
      repeat (2) @(posedge clk_50m);
      #1;
      check("irq_cleared", {31'd0, irq}, 32'd0);
      @(negedge clk_50m);
      s_busy = 1'b1;
      repeat (2) @(negedge clk_50m);
      s_busy = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      check("irq_abort", {31'd0, irq}, 32'd1);
`else
      cpu_write(8'h02, 16'h0001);
      cpu_read(8'h02, "rd_irq_absent", 16'h0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
